uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer between NUM_REQ byte producers, e.g. the debug/program loader echo path and CPU MMIO writes.
- Arbitrates pending requesters, latches the winning byte, and issues a single-cycle req to uart_tx only while uart_tx reports empty.
- Tracks the frame through to completion, then inserts an optional inter-byte gap.
- Guarantees uart_tx never sees req while busy, so uart_tx's error output stays low.

---
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte producers, one frame at a time.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int GAP_CYCLES = 0,
   parameter int IDX_WIDTH  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_req,
   input  logic                   tx_empty,
   input  logic                   tx_error,
   output logic                   busy,
   output logic [IDX_WIDTH-1:0]   grant_idx,
   output logic                   err_sticky
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE,
      GAP
   } state_e;

   state_e               state_q, state_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
   logic                 err_sticky_q, err_sticky_d;
   logic [7:0]           gap_cnt_q, gap_cnt_d;

   logic                 found;
   logic [IDX_WIDTH-1:0] win_idx;
   logic [7:0]           win_byte;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
   logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
`endif

   always_comb begin
      found   = 1'b0;
      win_idx = '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[k]) begin
            found   = 1'b1;
            win_idx = IDX_WIDTH'(k);
         end
      end
`else
      // Ports above the last winner first, then wrap around to those at or below it.
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[k] && (k > int'(ptr_q))) begin
            found   = 1'b1;
            win_idx = IDX_WIDTH'(k);
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[k] && (k <= int'(ptr_q))) begin
            found   = 1'b1;
            win_idx = IDX_WIDTH'(k);
         end
      end
`endif
   end

   always_comb begin
      win_byte = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_idx == IDX_WIDTH'(k)) begin
            win_byte = req_data[8*k +: 8];
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      tx_data_d    = tx_data_q;
      grant_idx_d  = grant_idx_q;
      gap_cnt_d    = gap_cnt_q;
      err_sticky_d = err_sticky_q | tx_error;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      ptr_d        = ptr_q;
`endif
      tx_req       = 1'b0;
      req_ready    = '0;

      case (state_q)
         IDLE: begin
            if (found && tx_empty) begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  req_ready[k] = (win_idx == IDX_WIDTH'(k));
               end
               tx_data_d   = win_byte;
               grant_idx_d = win_idx;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
               ptr_d       = win_idx;
`endif
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            // uart_tx only ever sees req while it reports empty.
            tx_req = tx_empty;
            if (tx_empty) begin
               state_d = WAIT_START;
            end
         end
         WAIT_START: begin
            if (!tx_empty) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_empty) begin
               if (GAP_CYCLES > 0) begin
                  state_d   = GAP;
                  gap_cnt_d = 8'(GAP_CYCLES - 1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tx_data_q    <= 8'h00;
         grant_idx_q  <= '0;
         err_sticky_q <= 1'b0;
         gap_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         tx_data_q    <= tx_data_d;
         grant_idx_q  <= grant_idx_d;
         err_sticky_q <= err_sticky_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

`ifndef UART_TX_ARB_FIXED_PRIO_EN
   // Pointer starts at the last port so port 0 wins the first search.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= IDX_WIDTH'(NUM_REQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign tx_data    = tx_data_q;
   assign grant_idx  = grant_idx_q;
   assign err_sticky = err_sticky_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: DUT A (2 ports, no gap) drives a 1-clk-per-bit uart_tx
// stand-in; DUT B (3 ports, 5-cycle gap) has its tx_empty driven by hand.
module tb_uart_tx_arbiter;
   localparam int NA    = 2;
   localparam int NB    = 3;
   localparam int GAP_B = 5;
   localparam int IW    = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NA-1:0]   a_req_valid, a_req_ready;
   logic [8*NA-1:0] a_req_data;
   logic [7:0]      a_tx_data;
   logic            a_tx_req, a_tx_empty, a_tx_error, a_busy, a_err_sticky, a_hold;
   logic [IW-1:0]   a_grant_idx;

   logic [NB-1:0]   b_req_valid, b_req_ready;
   logic [8*NB-1:0] b_req_data;
   logic [7:0]      b_tx_data;
   logic            b_tx_req, b_tx_empty, b_tx_error, b_busy, b_err_sticky;
   logic [IW-1:0]   b_grant_idx;

   int vectors     = 0;
   int miscompares = 0;

   uart_tx_arbiter #(.NUM_REQ(NA), .GAP_CYCLES(0), .IDX_WIDTH(IW)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_data(a_req_data),
      .req_ready(a_req_ready), .tx_data(a_tx_data), .tx_req(a_tx_req), .tx_empty(a_tx_empty),
      .tx_error(a_tx_error), .busy(a_busy), .grant_idx(a_grant_idx), .err_sticky(a_err_sticky)
   );

   uart_tx_arbiter #(.NUM_REQ(NB), .GAP_CYCLES(GAP_B), .IDX_WIDTH(IW)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_data(b_req_data),
      .req_ready(b_req_ready), .tx_data(b_tx_data), .tx_req(b_tx_req), .tx_empty(b_tx_empty),
      .tx_error(b_tx_error), .busy(b_busy), .grant_idx(b_grant_idx), .err_sticky(b_err_sticky)
   );

   // uart_tx stand-in: start bit, 8 data bits LSB-first, stop bit, one clk each.
   logic       m_empty;
   logic [9:0] m_shift;
   logic [3:0] m_cnt;
   logic       serial;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_empty <= 1'b1;
         m_cnt   <= 4'd0;
         m_shift <= 10'h3FF;
      end else if (a_tx_req && m_empty) begin
         m_shift <= {1'b1, a_tx_data, 1'b0};
         m_cnt   <= 4'd10;
         m_empty <= 1'b0;
      end else if (m_cnt != 4'd0) begin
         m_shift <= {1'b1, m_shift[9:1]};
         m_cnt   <= m_cnt - 4'd1;
         if (m_cnt == 4'd1) m_empty <= 1'b1;
      end
   end

   assign serial     = m_shift[0];
   assign a_tx_empty = m_empty & ~a_hold;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_a_idle(input string tag);
      int w;
      w = 0;
      while (a_busy && w < 40) begin
         tick();
         w++;
      end
      check(tag, a_busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] frame;
      logic [7:0] b_bytes [3];
      int         exp_idx [4];
      int         w;

      b_bytes = '{8'h11, 8'h22, 8'h33};
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      exp_idx = '{0, 0, 0, 0};
`else
      exp_idx = '{0, 1, 2, 0};
`endif

      rst_n       = 1'b0;
      a_req_valid = '0;
      a_req_data  = '0;
      a_tx_error  = 1'b0;
      a_hold      = 1'b0;
      b_req_valid = '0;
      b_req_data  = '0;
      b_tx_empty  = 1'b1;
      b_tx_error  = 1'b0;
      tick();
      tick();

      check("rst_busy", a_busy, 0);
      check("rst_tx_req", a_tx_req, 0);
      check("rst_tx_data", a_tx_data, 8'h00);
      check("rst_grant_idx", a_grant_idx, 0);
      check("rst_err", a_err_sticky, 0);
      check("rst_ready", a_req_ready, 0);
      check("rst_b_busy", b_busy, 0);
      rst_n = 1'b1;
      tick();

      // Single request from port 1
      a_req_data  = {8'hA5, 8'h00};
      a_req_valid = 2'b10;
      #1;
      check("single_ready", a_req_ready, 2'b10);
      check("single_txreq_c0", a_tx_req, 0);
      tick();
      a_req_valid = '0;
      #1;
      check("single_ready_once", a_req_ready, 0);
      check("single_txreq_c1", a_tx_req, 1);
      check("single_tx_data", a_tx_data, 8'hA5);
      check("single_grant_idx", a_grant_idx, 1);
      tick();
      check("single_txreq_c2", a_tx_req, 0);
      check("single_empty_c2", a_tx_empty, 0);
      frame = 10'b1_1010_0101_0;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("single_line_bit%0d", k), serial, frame[k]);
         check($sformatf("single_busy_bit%0d", k), a_busy, 1);
         tick();
      end
      check("single_empty_back", a_tx_empty, 1);
      check("single_busy_at_rise", a_busy, 1);
      tick();
      check("single_busy_after_rise", a_busy, 0);

      // Serializer busy at grant time
      a_hold      = 1'b1;
      a_req_data  = {8'h00, 8'h3C};
      a_req_valid = 2'b01;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("held_no_ready_%0d", k), a_req_ready, 0);
         check($sformatf("held_no_txreq_%0d", k), a_tx_req, 0);
         check($sformatf("held_idle_%0d", k), a_busy, 0);
         tick();
      end
      a_hold = 1'b0;
      #1;
      check("held_release_ready", a_req_ready, 2'b01);
      tick();
      a_req_valid = '0;
      #1;
      check("held_txreq", a_tx_req, 1);
      check("held_tx_data", a_tx_data, 8'h3C);
      check("held_grant_idx", a_grant_idx, 0);
      check("held_err", a_err_sticky, 0);
      wait_a_idle("held_done");
      check("held_err_end", a_err_sticky, 0);

      // Serializer goes busy while in ISSUE: tx_req must stay low until it is empty again
      a_req_data  = {8'h5A, 8'h00};
      a_req_valid = 2'b10;
      #1;
      check("stall_ready", a_req_ready, 2'b10);
      tick();
      a_req_valid = '0;
      a_hold      = 1'b1;
      #1;
      check("stall_txreq_0", a_tx_req, 0);
      tick();
      check("stall_txreq_1", a_tx_req, 0);
      check("stall_busy", a_busy, 1);
      a_hold = 1'b0;
      #1;
      check("stall_txreq_release", a_tx_req, 1);
      check("stall_tx_data", a_tx_data, 8'h5A);
      wait_a_idle("stall_done");

      // Error capture
      a_tx_error = 1'b1;
      #1;
      check("err_not_yet", a_err_sticky, 0);
      tick();
      a_tx_error = 1'b0;
      #1;
      check("err_set", a_err_sticky, 1);
      tick();
      tick();
      tick();
      check("err_holds", a_err_sticky, 1);

      // Contention and gap timing on DUT B
      b_req_data  = {b_bytes[2], b_bytes[1], b_bytes[0]};
      b_req_valid = 3'b111;
      #1;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         while (b_req_ready == '0 && w < 50) begin
            tick();
            w++;
         end
         // Grant lands on the cycle after GAP_B gap cycles that follow the tx_empty rise.
         if (i > 0) check($sformatf("gap_cycles_%0d", i), w, GAP_B + 1);
         check($sformatf("cont_ready_%0d", i), b_req_ready, 32'(1) << exp_idx[i]);
         tick();
         if (i == 3) b_req_valid = '0;
         check($sformatf("cont_txreq_%0d", i), b_tx_req, 1);
         check($sformatf("cont_tx_data_%0d", i), b_tx_data, b_bytes[exp_idx[i]]);
         check($sformatf("cont_grant_idx_%0d", i), b_grant_idx, exp_idx[i]);
         tick();
         b_tx_empty = 1'b0;
         tick();
         tick();
         check($sformatf("cont_busy_%0d", i), b_busy, 1);
         b_tx_empty = 1'b1;
         #1;
      end

      // Reset during WAIT_DONE
      a_req_data  = {8'hC3, 8'h00};
      a_req_valid = 2'b10;
      #1;
      check("rmf_ready", a_req_ready, 2'b10);
      tick();
      a_req_valid = '0;
      tick();
      tick();
      tick();
      check("rmf_busy_before", a_busy, 1);
      check("rmf_grant_before", a_grant_idx, 1);
      check("rmf_line_busy", a_tx_empty, 0);
      rst_n = 1'b0;
      #1;
      check("rmf_tx_req", a_tx_req, 0);
      check("rmf_busy", a_busy, 0);
      check("rmf_grant_idx", a_grant_idx, 0);
      check("rmf_tx_data", a_tx_data, 8'h00);
      check("rmf_err_cleared", a_err_sticky, 0);
      tick();
      rst_n = 1'b1;
      a_req_data  = {8'h77, 8'h66};
      a_req_valid = 2'b11;
      #1;
      check("rmf_first_port0", a_req_ready, 2'b01);
      tick();
      a_req_valid = 2'b10;
      #1;
      check("rmf_txreq", a_tx_req, 1);
      check("rmf_tx_data", a_tx_data, 8'h66);
      w = 0;
      while (a_req_ready == '0 && w < 40) begin
         tick();
         w++;
      end
      check("rmf_second_port1", a_req_ready, 2'b10);
      tick();
      a_req_valid = '0;
      #1;
      check("rmf_second_data", a_tx_data, 8'h77);
      wait_a_idle("rmf_done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
